// File: rtl/nibble_sub_sequencer_if.sv
// Request/result bundle between a controller and the nibble-serial subtractor.
// Latency: none (wires only).
// Backpressure: none; start is only honoured while the sequencer is idle.
interface nibble_sub_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int WIDTH = 4 * NIBBLES;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             ovf;

    // Requesting controller side
    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, zero, ovf
    );

    // Sequencer side
    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, zero, ovf
    );
endinterface

// File: rtl/nibble_sub_sequencer.sv
// Computes a - b - bin over WIDTH bits with one 4-bit subtractor, LS nibble first.
// Latency: done pulses NIBBLES cycles after the accepting edge; next accept NIBBLES+2 edges later.
// Backpressure: start is ignored (not queued) while busy or during the done cycle.
module nibble_sub_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nibble_sub_sequencer_if.slave  bus
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int MSB   = WIDTH - 1;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] work_q;

    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             zero_q;
    logic             ovf_q;

    // Shared 4-bit subtractor datapath
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [4:0]       nib_diff;
    logic [3:0]       nib_d;
    logic             nib_bout;
    logic [WIDTH-1:0] work_full;

    // Purely combinational nibble subtract; the borrow chain between nibbles
    // goes through borrow_q, so there is exactly one subtractor delay per cycle.
    always_comb begin
        nib_a     = a_q[{idx_q, 2'b00} +: 4];
        nib_b     = b_q[{idx_q, 2'b00} +: 4];
        nib_diff  = {1'b0, nib_a} - {1'b0, nib_b} - {4'b0000, borrow_q};
        nib_d     = nib_diff[3:0];
        nib_bout  = nib_diff[4];
        work_full = work_q;
        work_full[{idx_q, 2'b00} +: 4] = nib_d;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, walk the nibbles in RUN, single-cycle DONE
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (idx_q == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, per-nibble accumulation and final result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            work_q   <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.bin;
                        idx_q    <= '0;
                        work_q   <= '0;
                    end
                end
                RUN: begin
                    work_q   <= work_full;
                    borrow_q <= nib_bout;
                    idx_q    <= idx_q + 1'b1;
                    // Visible outputs change only once the whole word is known.
                    if (idx_q == LAST_IDX) begin
                        idx_q  <= '0;
                        d_q    <= work_full;
                        bout_q <= nib_bout;
                        zero_q <= (work_full == '0);
                        ovf_q  <= (a_q[MSB] != b_q[MSB]) && (work_full[MSB] != a_q[MSB]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_sub_sequencer.sv
// Randomized and directed checks of nibble_sub_sequencer against a word-level model.
// Latency: checks done arrives exactly NIBBLES cycles after acceptance, one cycle wide.
// Backpressure: start and operand noise is injected while busy and must be ignored.
module tb_nibble_sub_sequencer;
    localparam int NIBBLES = 4;
    localparam int WIDTH   = 4 * NIBBLES;

    logic clk;
    logic rst_n;

    nibble_sub_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_sub_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Last completed result the outputs must hold until the next completion
    logic [WIDTH-1:0] prev_d;
    logic             prev_bout;
    logic             prev_zero;
    logic             prev_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word-level reference: plain unsigned arithmetic one bit wider than the operands
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbin,
                         output logic [WIDTH-1:0] md, output logic mbout,
                         output logic mzero, output logic movf);
        logic [WIDTH:0] full;
        full  = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
        md    = full[WIDTH-1:0];
        mbout = full[WIDTH];
        mzero = (md == 0);
        movf  = (ma[WIDTH-1] != mb[WIDTH-1]) && (md[WIDTH-1] != ma[WIDTH-1]);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tbin);
        logic [WIDTH-1:0] ed;
        logic             eb, ez, eo;
        int               lat;
        bit               seen;
        model(ta, tb_, tbin, ed, eb, ez, eo);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.bin   = tbin;
        @(posedge clk);
        @(negedge clk);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                chk("busy_run", 32'(bus.busy), 32'd1);
                chk("hold_d", 32'(bus.d), 32'(prev_d));
                chk("hold_bout", 32'(bus.bout), 32'(prev_bout));
                chk("hold_zero", 32'(bus.zero), 32'(prev_zero));
                chk("hold_ovf", 32'(bus.ovf), 32'(prev_ovf));
                bus.start = 1'($urandom);
                bus.a     = WIDTH'($urandom);
                bus.b     = WIDTH'($urandom);
                bus.bin   = 1'($urandom);
                @(negedge clk);
                lat++;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(NIBBLES));
        chk("d", 32'(bus.d), 32'(ed));
        chk("bout", 32'(bus.bout), 32'(eb));
        chk("zero", 32'(bus.zero), 32'(ez));
        chk("ovf", 32'(bus.ovf), 32'(eo));
        chk("busy_done", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        @(negedge clk);
        chk("done_width", 32'(bus.done), 32'd0);
        chk("d_after", 32'(bus.d), 32'(ed));
        bus.start = 1'b0;
        prev_d    = ed;
        prev_bout = eb;
        prev_zero = ez;
        prev_ovf  = eo;
    endtask

    initial begin
        logic [WIDTH-1:0] ed;
        logic             eb, ez, eo;
        int               t0, t1, k;

        n_checks  = 0;
        n_errors  = 0;
        prev_d    = '0;
        prev_bout = 1'b0;
        prev_zero = 1'b0;
        prev_ovf  = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        rst_n     = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_d", 32'(bus.d), 32'd0);
        chk("rst_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_op(16'h1234, 16'h0234, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1);
        run_op(16'h7FFF, 16'hFFFF, 1'b0);
        run_op(16'h0000, 16'hFFFF, 1'b1);

        // Random operands
        for (int i = 0; i < 40; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end

        // start held high: back-to-back operations every NIBBLES+2 cycles
        model(16'hA5A5, 16'h1111, 1'b1, ed, eb, ez, eo);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'hA5A5;
        bus.b     = 16'h1111;
        bus.bin   = 1'b1;
        t0 = -1;
        t1 = -1;
        k  = 0;
        while (t1 < 0 && k < 40) begin
            @(negedge clk);
            k++;
            if (bus.done) begin
                if (t0 < 0) t0 = k;
                else        t1 = k;
            end
        end
        chk("b2b_seen", 32'(t1 >= 0), 32'd1);
        chk("b2b_period", 32'(t1 - t0), 32'(NIBBLES + 2));
        chk("b2b_d", 32'(bus.d), 32'(ed));
        bus.start = 1'b0;
        repeat (NIBBLES + 3) @(negedge clk);
        prev_d    = ed;
        prev_bout = eb;
        prev_zero = ez;
        prev_ovf  = eo;

        // Asynchronous reset mid-RUN aborts with no done pulse
        run_op(16'h1234, 16'h0234, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_d", 32'(bus.d), 32'd0);
        chk("arst_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("arst_nodone", 32'(bus.done), 32'd0);
        end
        rst_n     = 1'b1;
        prev_d    = '0;
        prev_bout = 1'b0;
        prev_zero = 1'b0;
        prev_ovf  = 1'b0;
        run_op(16'hFFFF, 16'h0F0F, 1'b0);
        chk("post_rst_d", 32'(prev_d), 32'h0000F0F0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nibble_sub_sequencer.md
# nibble_sub_sequencer

Multi-cycle controller that computes a WIDTH-bit difference A − B − bin using one shared 4-bit `parallelSubtractor` instance, one nibble per clock, least-significant nibble first. It latches the operands, feeds each nibble and the stored borrow into the subtractor, and assembles the result. It then presents the final difference, borrow-out, zero and signed-overflow flags with a one-cycle `done` pulse. The block sits between a requesting controller and the existing 4-bit subtractor datapath, so wide subtractions do not need a wide array.

## Interface
- NIBBLES, 4, number of 4-bit passes; WIDTH = 4*NIBBLES (default 16); legal range 2..8
- clk  in  1  single system clock, rising-edge active
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  minuend; sampled on the accepting edge
- b  in  WIDTH  subtrahend; sampled on the accepting edge
- bin  in  1  borrow-in to nibble 0; sampled on the accepting edge
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result outputs are valid from this cycle on
- d  out  WIDTH  registered difference
- bout  out  1  borrow-out of the most-significant nibble
- zero  out  1  d == 0
- ovf  out  1  signed overflow: (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), using latched operands

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch a, b and bin into internal registers, clear the nibble index, go to RUN. With start=0 the block stays in IDLE.
- RUN, each edge:
  - The subtractor gets latched a/b nibble[idx] and the borrow register (initially the latched bin).
  - Its `d` is written into working-result nibble[idx] and its `bout` into the borrow register; idx increments.
- RUN, at idx == NIBBLES-1:
  - On the same edge, copy the completed working result into `d` and the final borrow into `bout`.
  - Compute `zero` and `ovf` from the completed result and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE, with no queuing. Operand changes after acceptance have no effect.
- d/bout/zero/ovf hold the last completed result until the next completion. They never show partial nibbles.
- Arithmetic is modulo 2^WIDTH. bout=1 means a < b + bin when both are taken as unsigned.
- The subtractor instance is purely combinational. It has no registered path of its own.

## Timing
- Reset (rst_n=0, asynchronous): state returns to IDLE. busy, done, d, bout, zero and ovf go to 0. idx, working result and borrow register clear. Reset during RUN aborts the operation with no done pulse.
- Latency: start is accepted at edge E0. busy is high after E0 through edge E(NIBBLES). Results update at edge E(NIBBLES). done is high in the cycle between E(NIBBLES) and E(NIBBLES+1).
- Default NIBBLES=4: done appears 4 cycles after acceptance. The earliest next acceptance is edge E(NIBBLES+2), so throughput is one operation per NIBBLES+2 cycles.
- start held high continuously: a new operation is accepted each time IDLE is re-entered.
- Nibble-to-nibble borrow path: one subtractor delay per cycle, no ripple across nibbles within a cycle.

## Test plan
- a=0x1234, b=0x0234, bin=0 -> after 4 cycles: d=0x1000, bout=0, zero=0, ovf=0, done pulse of width 1.
- a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1, zero=0, ovf=0. Also checks borrow propagation through all nibbles.
- a=0x8000, b=0x0001, bin=0 -> d=0x7FFF, bout=0, ovf=1.
- a=0x0005, b=0x0005, bin=0 -> d=0x0000, zero=1, bout=0. Repeat with bin=1 -> d=0xFFFF, bout=1, zero=0.
- start pulses and operand changes while busy=1 -> ignored. d, done count and latency are unchanged, and d still shows the previous result until completion.
- rst_n low at cycle 2 of RUN, asynchronously mid-cycle -> outputs become 0 immediately with no done pulse. A following start with a=0xFFFF, b=0x0F0F gives d=0xF0F0, bout=0.
